mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: bus handshake, lane placement,
// load extraction, misalignment and timeout fault reporting.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [2:0]    r_f3;
    logic [1:0]    r_lane;
    logic          r_we;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_valid;
    logic          r_fault;

    logic          w_access;
    logic          w_illegal;
    logic          w_last;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ld;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_access  = mem_valid & (mem_read | mem_write);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc >= TMO);

    // Legality of the presented access; a write wins over a read.
    always_comb begin
        w_illegal = 1'b0;
        if (mem_write) begin
            w_illegal = (funct3[2] | (funct3[1:0] == 2'd3))
                      | ((funct3 == 3'd1) & addr[0])
                      | ((funct3 == 3'd2) & (addr[1:0] != 2'd0));
        end else begin
            w_illegal = (funct3 == 3'd3) | (funct3 == 3'd6)
                      | (funct3 == 3'd7)
                      | ((funct3[1:0] == 2'd1) & addr[0])
                      | ((funct3 == 3'd2) & (addr[1:0] != 2'd0));
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        unique case (funct3[1:0])
            2'd0: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    // Load extraction from the returned word using the latched lane.
    always_comb begin
        w_byte = bus_rdata[7:0];
        unique case (r_lane)
            2'd0: w_byte = bus_rdata[7:0];
            2'd1: w_byte = bus_rdata[15:8];
            2'd2: w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (r_f3)
            3'd0: w_ld = {{24{w_byte[7]}}, w_byte};
            3'd1: w_ld = {{16{w_half[15]}}, w_half};
            3'd4: w_ld = {24'd0, w_byte};
            3'd5: w_ld = {16'd0, w_half};
            default: w_ld = bus_rdata;
        endcase
    end

    // Next state and the combinational stall.
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    stall  = 1'b1;
                    w_next = w_illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus_ack || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: latch the access, drive the bus, capture the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_f3    <= '0;
            r_lane  <= '0;
            r_we    <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_access && w_illegal) begin
                        r_fault <= 1'b1;
                        r_rdata <= '0;
                        r_valid <= 1'b1;
                    end else if (w_access) begin
                        r_cnt   <= '0;
                        r_f3    <= funct3;
                        r_lane  <= addr[1:0];
                        r_we    <= mem_write;
                        r_req   <= 1'b1;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_fault <= bus_err;
                        r_rdata <= (bus_err || r_we) ? 32'd0 : w_ld;
                    end else if (w_last) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_fault <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_req     = r_req;
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_be      = r_be;
    assign rdata       = r_rdata;
    assign rdata_valid = r_valid;
    assign fault       = r_fault;

endmodule
